// File: rtl/lifo_fifo_buffer_pkg.sv
// Shared definitions for the LIFO/FIFO buffer.
// - MODE_FIFO / MODE_LIFO : encoding of the mode input and the latched mode
// - ptr_next()            : circular pointer increment for non power-of-two depths
package lifo_fifo_buffer_pkg;

    localparam logic MODE_FIFO = 1'b0;
    localparam logic MODE_LIFO = 1'b1;

    // Wraps depth-1 back to 0 so DEPTH need not be a power of two.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/buffer_ram.sv
// Storage array for the LIFO/FIFO buffer.
// Ports:
//   clock : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : read data
// Contents are not reset.
module buffer_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_fifo_buffer.sv
// Run-time selectable stack/queue buffer over a single storage array.
// Ports:
//   clock, reset        : clock and asynchronous active-high reset
//   mode                : 0 = FIFO, 1 = LIFO; only taken while the buffer is empty
//   write, read, datain : push/pop requests and write data
//   dataout, rd_valid   : registered read data and its one-cycle strobe
//   full, empty         : occupancy limits (combinational from count)
//   almost_full/empty   : threshold flags (combinational from count)
//   count               : current occupancy, 0..DEPTH
//   overflow, underflow : sticky error flags, cleared only by reset
module lifo_fifo_buffer
    import lifo_fifo_buffer_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_TH  = DEPTH - 1,
    parameter int unsigned AEMPTY_TH = 1,
    parameter int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mode,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rv_q, rv_d, ovf_q, ovf_d, unf_q, unf_d;

    logic              is_empty, is_full, eff_mode;
    logic [PTR_W-1:0]  wr_base, rd_base, lifo_top, lifo_slot;
    logic              ram_we;
    logic [PTR_W-1:0]  ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    buffer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (datain),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    // While empty the mode input takes effect on this very edge and the pointers restart at 0.
    assign eff_mode  = is_empty ? mode : mode_q;
    assign wr_base   = is_empty ? '0 : wr_ptr_q;
    assign rd_base   = is_empty ? '0 : rd_ptr_q;
    assign lifo_top  = PTR_W'(count_q - 1'b1);
    assign lifo_slot = PTR_W'(count_q);

    assign ram_raddr = (eff_mode == MODE_LIFO) ? lifo_top : rd_base;
    assign ram_waddr = (eff_mode == MODE_LIFO) ? lifo_slot : wr_base;

    always_comb begin
        wr_ptr_d = wr_base;
        rd_ptr_d = rd_base;
        count_d  = count_q;
        mode_d   = eff_mode;
        dout_d   = dout_q;
        rv_d     = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ram_we   = 1'b0;
        case ({write, read})
            2'b10: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    ram_we  = 1'b1;
                    count_d = count_q + 1'b1;
                    if (eff_mode == MODE_FIFO) begin
                        wr_ptr_d = PTR_W'(ptr_next(32'(wr_base), DEPTH));
                    end
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    dout_d  = ram_rdata;
                    rv_d    = 1'b1;
                    count_d = count_q - 1'b1;
                    if (eff_mode == MODE_FIFO) begin
                        rd_ptr_d = PTR_W'(ptr_next(32'(rd_base), DEPTH));
                    end
                end
            end
            2'b11: begin
                rv_d = 1'b1;
                if (is_empty || eff_mode == MODE_LIFO) begin
                    // Bypass: the pushed word is popped straight back out.
                    dout_d = datain;
                end else begin
                    // Async read returns the old word even when rd_ptr == wr_ptr (full).
                    dout_d   = ram_rdata;
                    ram_we   = 1'b1;
                    wr_ptr_d = PTR_W'(ptr_next(32'(wr_base), DEPTH));
                    rd_ptr_d = PTR_W'(ptr_next(32'(rd_base), DEPTH));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mode_q   <= MODE_FIFO;
            dout_q   <= '0;
            rv_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            dout_q   <= dout_d;
            rv_q     <= rv_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign dataout      = dout_q;
    assign rd_valid     = rv_q;
    assign count        = count_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign almost_full  = (count_q >= CNT_W'(AFULL_TH));
    assign almost_empty = (count_q <= CNT_W'(AEMPTY_TH));
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Self-checking bench: queue-based reference model, directed scenarios, then random traffic.
module tb_lifo_fifo_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              mode = 1'b0, write = 1'b0, read = 1'b0;
    logic [DATA_W-1:0] datain = '0;
    logic [DATA_W-1:0] dataout;
    logic              rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CNT_W-1:0]  count;

    lifo_fifo_buffer #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_TH  (3),
        .AEMPTY_TH (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mode         (mode),
        .write        (write),
        .read         (read),
        .datain       (datain),
        .dataout      (dataout),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    // Reference model: the queue holds entries oldest first; the stack top is the back.
    logic [7:0] mq[$];
    logic       m_mode, m_rv, m_ovf, m_unf;
    logic [7:0] m_dout;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = 1'b0;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = 8'h00;
    endtask

    task automatic model_step(input logic w, input logic r, input logic m, input logic [7:0] d);
        if (mq.size() == 0) m_mode = m;
        m_rv = 1'b0;
        if (w && !r) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(d);
        end else if (r && !w) begin
            if (mq.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                m_rv   = 1'b1;
                m_dout = m_mode ? mq.pop_back() : mq.pop_front();
            end
        end else if (r && w) begin
            m_rv = 1'b1;
            if (mq.size() == 0 || m_mode) begin
                m_dout = d;
            end else begin
                m_dout = mq.pop_front();
                mq.push_back(d);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        int n;
        n = mq.size();
        check_eq({tag, ".count"}, 32'(count), 32'(n));
        check_eq({tag, ".dataout"}, 32'(dataout), 32'(m_dout));
        check_eq({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rv));
        check_eq({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        check_eq({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check_eq({tag, ".almost_full"}, 32'(almost_full), 32'(n >= 3));
        check_eq({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 1));
        check_eq({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check_eq({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
    task automatic step(input string tag, input logic w, input logic r, input logic m,
                        input logic [7:0] d);
        write  = w;
        read   = r;
        mode   = m;
        datain = d;
        @(posedge clock);
        model_step(w, r, m, d);
        #1;
        compare_all(tag);
    endtask

    // Asserts reset between edges and checks the outputs clear before any edge.
    task automatic apply_reset(input string tag);
        write = 1'b0;
        read  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all({tag, ".async"});
        @(posedge clock);
        #1;
        reset = 1'b0;
        compare_all({tag, ".held"});
    endtask

    initial begin
        model_reset();
        #1;
        compare_all("por");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // LIFO fill and drain
        for (int i = 0; i < 4; i++) step("lifo_wr", 1'b1, 1'b0, 1'b1, 8'((i + 1) * 17));
        check_eq("lifo_full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step("lifo_rd", 1'b0, 1'b1, 1'b1, 8'h00);
            check_eq("lifo_order", 32'(dataout), 32'((4 - i) * 17));
        end
        step("idle", 1'b0, 1'b0, 1'b0, 8'h00);

        // FIFO fill, overflow, drain, underflow
        for (int i = 0; i < 4; i++) step("fifo_wr", 1'b1, 1'b0, 1'b0, 8'((i + 1) * 17));
        step("fifo_ovf", 1'b1, 1'b0, 1'b0, 8'hEE);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step("fifo_rd", 1'b0, 1'b1, 1'b0, 8'h00);
            check_eq("fifo_order", 32'(dataout), 32'((i + 1) * 17));
        end
        step("fifo_unf", 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("unf_hold", 32'(dataout), 32'h44);

        // FIFO pointer wrap
        for (int i = 0; i < 4; i++) step("wrap_wr", 1'b1, 1'b0, 1'b0, 8'((i + 1) * 17));
        step("wrap_rd", 1'b0, 1'b1, 1'b0, 8'h00);
        step("wrap_rd", 1'b0, 1'b1, 1'b0, 8'h00);
        step("wrap_wr2", 1'b1, 1'b0, 1'b0, 8'h55);
        step("wrap_wr2", 1'b1, 1'b0, 1'b0, 8'h66);
        for (int i = 0; i < 4; i++) step("wrap_drain", 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("wrap_last", 32'(dataout), 32'h66);

        // FIFO full with simultaneous read and write
        for (int i = 0; i < 4; i++) step("frw_wr", 1'b1, 1'b0, 1'b0, 8'((i + 1) * 17));
        step("frw", 1'b1, 1'b1, 1'b0, 8'hAA);
        check_eq("frw_oldest", 32'(dataout), 32'h11);
        for (int i = 0; i < 4; i++) step("frw_drain", 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("frw_tail", 32'(dataout), 32'hAA);

        // LIFO bypass, then mode toggle ignored while occupied
        step("lrw_wr", 1'b1, 1'b0, 1'b1, 8'h01);
        step("lrw_wr", 1'b1, 1'b0, 1'b1, 8'h02);
        step("lrw", 1'b1, 1'b1, 1'b1, 8'hBB);
        check_eq("lrw_bypass", 32'(dataout), 32'hBB);
        step("tog_rd", 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("tog_lifo", 32'(dataout), 32'h02);
        step("tog_rd", 1'b0, 1'b1, 1'b0, 8'h00);
        step("tog_wr", 1'b1, 1'b0, 1'b0, 8'h07);
        step("tog_wr", 1'b1, 1'b0, 1'b0, 8'h08);
        step("tog_rd2", 1'b0, 1'b1, 1'b1, 8'h00);
        check_eq("tog_fifo", 32'(dataout), 32'h07);
        step("tog_rd2", 1'b0, 1'b1, 1'b1, 8'h00);
        step("empty_rw", 1'b1, 1'b1, 1'b0, 8'h3C);

        // Asynchronous reset mid-burst with sticky flags set
        for (int i = 0; i < 3; i++) step("burst", 1'b1, 1'b0, 1'b0, 8'(i + 1));
        apply_reset("midrst");
        step("post_rst", 1'b1, 1'b0, 1'b1, 8'h5A);
        step("post_rst", 1'b0, 1'b1, 1'b0, 8'h00);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic w, r, m;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            m = ($urandom_range(0, 99) < 50);
            if ($urandom_range(0, 299) == 0) apply_reset("rnd_rst");
            else step("rnd", w, r, m, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
